// File: rtl/tm1638_responder.sv
// tm1638_responder: slave side of a TM1638-style three-wire display/key link.
// Holds the 16-byte display RAM and the display control settings.
// Also answers key-read frames on the bidirectional sio_data line.
// Optional feature: define TM1638_RESPONDER_PROTO_ERR_EN to add the sticky proto_err output.
`timescale 1ns/1ps
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sio_clk,
    input  logic         sio_stb,
    inout  wire          sio_data,
    input  logic [31:0]  key_scan,
    output logic [127:0] disp_ram,
    output logic         disp_on,
    output logic [2:0]   brightness,
    output logic         upd
`ifdef TM1638_RESPONDER_PROTO_ERR_EN
    ,
    output logic         proto_err
`endif
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_DATA, ST_KEY, ST_SKIP, ST_NULL} state_t;

    state_t         state, state_nx;
    logic [SS-1:0]  clk_sync, stb_sync, dat_sync;
    logic           clk_prev_p1, stb_prev_p1;
    logic           clk_rise, clk_fall, stb_rise, stb_fall;
    logic [2:0]     bit_cnt;
    logic [6:0]     shreg;
    logic [7:0]     byte_in;
    logic           shifting, byte_done;
    logic           mode_fixed, dirty;
    logic [3:0]     addr;
    logic           wr_vld_p0, wr_chg;
    logic [3:0]     wr_addr_p0;
    logic [7:0]     wr_byte_p0;
    logic [31:0]    key_q;
    logic [5:0]     key_cnt;
    logic           drive_en, drive_bit;

    assign sio_data  = drive_en ? drive_bit : 1'bz;
    assign clk_rise  =  clk_sync[SS-1] & ~clk_prev_p1;
    assign clk_fall  = ~clk_sync[SS-1] &  clk_prev_p1;
    assign stb_rise  =  stb_sync[SS-1] & ~stb_prev_p1;
    assign stb_fall  = ~stb_sync[SS-1] &  stb_prev_p1;
    assign byte_in   = {dat_sync[SS-1], shreg};
    assign shifting  = (state == ST_CMD) || (state == ST_DATA) || (state == ST_SKIP) || (state == ST_NULL);
    assign byte_done = clk_rise && shifting && (bit_cnt == 3'd7) && !stb_rise;
    assign wr_chg    = wr_vld_p0 && (disp_ram[{wr_addr_p0, 3'b000} +: 8] != wr_byte_p0);

    // Control synchronizers; strobe starts low so a strobe held low through reset never looks like a fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync    <= '0;
            stb_sync    <= '0;
            clk_prev_p1 <= 1'b0;
            stb_prev_p1 <= 1'b0;
        end else begin
            clk_sync    <= {clk_sync[SS-2:0], sio_clk};
            stb_sync    <= {stb_sync[SS-2:0], sio_stb};
            clk_prev_p1 <= clk_sync[SS-1];
            stb_prev_p1 <= stb_sync[SS-1];
        end
    end

    // Data synchronizer, same depth as the clock path so sampled bits stay aligned with clock edges.
    always_ff @(posedge clk) begin
        dat_sync <= {dat_sync[SS-2:0], sio_data};
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next frame state: strobe edges bound the frame, the first byte picks the command class.
    always_comb begin
        state_nx = state;
        if (stb_rise) begin
            state_nx = ST_IDLE;
        end else if (stb_fall) begin
            state_nx = ST_CMD;
        end else if (byte_done && state == ST_CMD) begin
            case (byte_in[7:6])
                2'b01:   state_nx = byte_in[1] ? ST_KEY : ST_SKIP;
                2'b10:   state_nx = ST_SKIP;
                2'b11:   state_nx = ST_DATA;
                default: state_nx = ST_NULL;
            endcase
        end
    end

    // Bit counter; any strobe edge discards a partial byte.
    always_ff @(posedge clk) begin
        if (!rst_n || stb_rise || stb_fall) bit_cnt <= '0;
        else if (clk_rise && shifting)      bit_cnt <= bit_cnt + 3'd1;
    end

    // LSB-first shift register for incoming bits.
    always_ff @(posedge clk) begin
        if (clk_rise && shifting) shreg <= byte_in[7:1];
    end

    // Command decode, address/mode/display control and the frame-end update pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_fixed <= 1'b0;
            addr       <= '0;
            disp_on    <= 1'b0;
            brightness <= '0;
            wr_vld_p0  <= 1'b0;
            dirty      <= 1'b0;
            upd        <= 1'b0;
        end else begin
            wr_vld_p0 <= 1'b0;
            upd       <= stb_rise && (state != ST_IDLE) && (dirty || wr_chg);
            if (stb_rise || stb_fall) dirty <= 1'b0;
            else if (wr_chg)          dirty <= 1'b1;
            if (byte_done) begin
                case (state)
                    ST_CMD: begin
                        case (byte_in[7:6])
                            2'b01: mode_fixed <= byte_in[2];
                            2'b10: begin
                                if (byte_in[3:0] != {disp_on, brightness}) dirty <= 1'b1;
                                disp_on    <= byte_in[3];
                                brightness <= byte_in[2:0];
                            end
                            2'b11: addr <= byte_in[3:0];
                            default: ;
                        endcase
                    end
                    ST_DATA: begin
                        wr_vld_p0 <= 1'b1;
                        if (!mode_fixed) addr <= addr + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Write data/address captured with the completed byte, committed one cycle later.
    always_ff @(posedge clk) begin
        if (byte_done && state == ST_DATA) begin
            wr_addr_p0 <= addr;
            wr_byte_p0 <= byte_in;
        end
    end

    // Display RAM write port.
    always_ff @(posedge clk) begin
        if (!rst_n)         disp_ram <= '0;
        else if (wr_vld_p0) disp_ram[{wr_addr_p0, 3'b000} +: 8] <= wr_byte_p0;
    end

    // Key read output enable: one bit per sio_clk fall, released on the fall after bit 31 or at frame end.
    always_ff @(posedge clk) begin
        if (!rst_n || stb_rise) begin
            drive_en <= 1'b0;
            key_cnt  <= '0;
        end else if (state == ST_KEY && clk_fall) begin
            if (!key_cnt[5]) begin
                drive_en <= 1'b1;
                key_cnt  <= key_cnt + 6'd1;
            end else begin
                drive_en <= 1'b0;
            end
        end
    end

    // Key snapshot at the read command and the bit currently presented.
    always_ff @(posedge clk) begin
        if (byte_done && state == ST_CMD && byte_in[7:6] == 2'b01 && byte_in[1]) key_q <= key_scan;
        if (state == ST_KEY && clk_fall && !key_cnt[5]) drive_bit <= key_q[key_cnt[4:0]];
    end

`ifdef TM1638_RESPONDER_PROTO_ERR_EN
    // Sticky protocol error: partial byte at frame end, 00 command, or bytes after data/display command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if ((stb_rise && shifting && bit_cnt != 3'd0) ||
                     (byte_done && state == ST_SKIP) ||
                     (byte_done && state == ST_CMD && byte_in[7:6] == 2'b00)) begin
            proto_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
// tb_tm1638_responder: directed bench for tm1638_responder acting as the serial controller.
// A pulldown on sio_data makes a released line read 0, so release is visible after a driven 1.
`timescale 1ns/1ps
module tb_tm1638_responder;

    localparam int HALF = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sio_clk = 1'b1;
    logic         sio_stb = 1'b1;
    logic         tb_drv_en = 1'b0;
    logic         tb_drv_val = 1'b0;
    wire          sio_data;
    logic [31:0]  key_scan = 32'h0;
    logic [127:0] disp_ram;
    logic         disp_on;
    logic [2:0]   brightness;
    logic         upd;
`ifdef TM1638_RESPONDER_PROTO_ERR_EN
    logic         proto_err;
`endif

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;
    logic [127:0] ram_exp = '0;

    assign sio_data = tb_drv_en ? tb_drv_val : 1'bz;
    pulldown (sio_data);

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sio_clk    (sio_clk),
        .sio_stb    (sio_stb),
        .sio_data   (sio_data),
        .key_scan   (key_scan),
        .disp_ram   (disp_ram),
        .disp_on    (disp_on),
        .brightness (brightness),
        .upd        (upd)
`ifdef TM1638_RESPONDER_PROTO_ERR_EN
        ,
        .proto_err  (proto_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upd === 1'b1) upd_cnt = upd_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=still running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        tb_drv_en = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            sio_clk = 1'b0;
            tb_drv_val = b[i];
            wait_clk(HALF);
            sio_clk = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic frame_begin;
        sio_stb = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end;
        sio_stb = 1'b1;
        tb_drv_en = 1'b0;
        wait_clk(10);
    endtask

    task automatic frame1(input logic [7:0] b);
        frame_begin;
        send_bits(b, 8);
        frame_end;
    endtask

    task automatic read_byte(output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            sio_clk = 1'b0;
            wait_clk(HALF);
            b[i] = sio_data;
            sio_clk = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_clk(3);
        checks++; if (disp_ram !== 128'h0) begin errors++; $display("FAIL reset_ram got=%h exp=0", disp_ram); end
        checks++; if (disp_on !== 1'b0) begin errors++; $display("FAIL reset_disp_on got=%b exp=0", disp_on); end
        checks++; if (brightness !== 3'd0) begin errors++; $display("FAIL reset_brightness got=%0d exp=0", brightness); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b exp=0", upd); end
        checks++; if (sio_data !== 1'b0) begin errors++; $display("FAIL reset_sio_release got=%b exp=0", sio_data); end
        rst_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic test_auto_write;
        int u0;
        u0 = upd_cnt;
        frame1(8'h40);
        checks++; if (upd_cnt !== u0) begin errors++; $display("FAIL auto_cmd_upd got=%0d exp=%0d", upd_cnt, u0); end
        frame_begin;
        send_bits(8'hC0, 8); send_bits(8'h3F, 8); send_bits(8'h06, 8); send_bits(8'h5B, 8);
        frame_end;
        ram_exp[23:0] = 24'h5B063F;
        checks++; if (disp_ram !== ram_exp) begin errors++; $display("FAIL auto_ram got=%h exp=%h", disp_ram, ram_exp); end
        checks++; if (upd_cnt !== u0 + 1) begin errors++; $display("FAIL auto_upd got=%0d exp=%0d", upd_cnt - u0, 1); end
    endtask

    task automatic test_fixed_wrap;
        int u0;
        frame1(8'h44);
        u0 = upd_cnt;
        frame_begin;
        send_bits(8'hCF, 8); send_bits(8'h11, 8); send_bits(8'h22, 8);
        frame_end;
        checks++; if (disp_ram[127:120] !== 8'h22) begin errors++; $display("FAIL fixed_a15 got=%h exp=22", disp_ram[127:120]); end
        checks++; if (disp_ram[7:0] !== 8'h3F) begin errors++; $display("FAIL fixed_a0 got=%h exp=3F", disp_ram[7:0]); end
        checks++; if (upd_cnt !== u0 + 1) begin errors++; $display("FAIL fixed_upd got=%0d exp=1", upd_cnt - u0); end
        frame1(8'h40);
        frame_begin;
        send_bits(8'hCF, 8); send_bits(8'hAA, 8); send_bits(8'hBB, 8);
        frame_end;
        ram_exp[127:120] = 8'hAA;
        ram_exp[7:0] = 8'hBB;
        checks++; if (disp_ram[127:120] !== 8'hAA) begin errors++; $display("FAIL wrap_a15 got=%h exp=AA", disp_ram[127:120]); end
        checks++; if (disp_ram[7:0] !== 8'hBB) begin errors++; $display("FAIL wrap_a0 got=%h exp=BB", disp_ram[7:0]); end
        checks++; if (disp_ram !== ram_exp) begin errors++; $display("FAIL wrap_ram got=%h exp=%h", disp_ram, ram_exp); end
    endtask

    task automatic test_display;
        int u0;
        u0 = upd_cnt;
        frame1(8'h8C);
        checks++; if (disp_on !== 1'b1) begin errors++; $display("FAIL disp_on_8c got=%b exp=1", disp_on); end
        checks++; if (brightness !== 3'd4) begin errors++; $display("FAIL bright_8c got=%0d exp=4", brightness); end
        checks++; if (upd_cnt !== u0 + 1) begin errors++; $display("FAIL disp_upd_8c got=%0d exp=1", upd_cnt - u0); end
        frame1(8'h80);
        checks++; if (disp_on !== 1'b0) begin errors++; $display("FAIL disp_on_80 got=%b exp=0", disp_on); end
        checks++; if (brightness !== 3'd0) begin errors++; $display("FAIL bright_80 got=%0d exp=0", brightness); end
        checks++; if (upd_cnt !== u0 + 2) begin errors++; $display("FAIL disp_upd_80 got=%0d exp=2", upd_cnt - u0); end
        frame_begin;
        send_bits(8'h8F, 8); send_bits(8'hFF, 8); send_bits(8'hC3, 8);
        frame_end;
        checks++; if ({disp_on, brightness} !== 4'hF) begin errors++; $display("FAIL disp_8f got=%h exp=F", {disp_on, brightness}); end
        checks++; if (disp_ram !== ram_exp) begin errors++; $display("FAIL disp_extra_bytes got=%h exp=%h", disp_ram, ram_exp); end
    endtask

    task automatic test_null_cmd;
        int u0;
        u0 = upd_cnt;
        frame_begin;
        send_bits(8'h00, 8); send_bits(8'hC0, 8); send_bits(8'h12, 8);
        frame_end;
        checks++; if (disp_ram !== ram_exp) begin errors++; $display("FAIL null_ram got=%h exp=%h", disp_ram, ram_exp); end
        checks++; if (upd_cnt !== u0) begin errors++; $display("FAIL null_upd got=%0d exp=0", upd_cnt - u0); end
`ifdef TM1638_RESPONDER_PROTO_ERR_EN
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL null_proto_err got=%b exp=1", proto_err); end
`endif
    endtask

    task automatic test_key_read;
        logic [7:0] rb;
        logic [7:0] exp_b [4];
        int u0;
        exp_b[0] = 8'h04; exp_b[1] = 8'h02; exp_b[2] = 8'h01; exp_b[3] = 8'h80;
        key_scan = 32'h8001_0204;
        u0 = upd_cnt;
        frame_begin;
        send_bits(8'h42, 8);
        tb_drv_en = 1'b0;
        key_scan = 32'h0;
        for (int k = 0; k < 4; k++) begin
            read_byte(rb);
            checks++; if (rb !== exp_b[k]) begin errors++; $display("FAIL key_byte%0d got=%h exp=%h", k, rb, exp_b[k]); end
        end
        sio_clk = 1'b0;
        wait_clk(HALF);
        checks++; if (sio_data !== 1'b0) begin errors++; $display("FAIL key_release_after32 got=%b exp=0", sio_data); end
        sio_clk = 1'b1;
        wait_clk(HALF);
        frame_end;
        checks++; if (sio_data !== 1'b0) begin errors++; $display("FAIL key_release_stb got=%b exp=0", sio_data); end
        checks++; if (upd_cnt !== u0) begin errors++; $display("FAIL key_upd got=%0d exp=0", upd_cnt - u0); end
    endtask

    task automatic test_key_abort;
        key_scan = 32'h8001_0204;
        frame_begin;
        send_bits(8'h42, 8);
        tb_drv_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sio_clk = 1'b0;
            wait_clk(HALF);
            if (i == 2) begin
                checks++; if (sio_data !== 1'b1) begin errors++; $display("FAIL abort_bit2 got=%b exp=1", sio_data); end
            end
            sio_clk = 1'b1;
            wait_clk(HALF);
        end
        frame_end;
        checks++; if (sio_data !== 1'b0) begin errors++; $display("FAIL abort_release got=%b exp=0", sio_data); end
    endtask

    task automatic test_partial;
        int u0;
        u0 = upd_cnt;
        frame_begin;
        send_bits(8'hC5, 8);
        send_bits(8'h99, 5);
        frame_end;
        checks++; if (disp_ram !== ram_exp) begin errors++; $display("FAIL partial_ram got=%h exp=%h", disp_ram, ram_exp); end
        checks++; if (upd_cnt !== u0) begin errors++; $display("FAIL partial_upd got=%0d exp=0", upd_cnt - u0); end
`ifdef TM1638_RESPONDER_PROTO_ERR_EN
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL partial_proto_err got=%b exp=1", proto_err); end
`endif
        frame_begin;
        send_bits(8'hC5, 8); send_bits(8'h77, 8);
        frame_end;
        ram_exp[47:40] = 8'h77;
        checks++; if (disp_ram !== ram_exp) begin errors++; $display("FAIL after_partial_ram got=%h exp=%h", disp_ram, ram_exp); end
        checks++; if (upd_cnt !== u0 + 1) begin errors++; $display("FAIL after_partial_upd got=%0d exp=1", upd_cnt - u0); end
    endtask

    task automatic test_reset_midframe;
        int u0;
        frame_begin;
        send_bits(8'hC0, 8); send_bits(8'h55, 8);
        send_bits(8'h66, 3);
        rst_n = 1'b0;
        wait_clk(3);
        checks++; if (disp_ram !== 128'h0) begin errors++; $display("FAIL midrst_ram got=%h exp=0", disp_ram); end
        checks++; if ({disp_on, brightness} !== 4'h0) begin errors++; $display("FAIL midrst_ctl got=%h exp=0", {disp_on, brightness}); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL midrst_upd got=%b exp=0", upd); end
`ifdef TM1638_RESPONDER_PROTO_ERR_EN
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL midrst_proto_err got=%b exp=0", proto_err); end
`endif
        rst_n = 1'b1;
        u0 = upd_cnt;
        send_bits(8'h66, 5);
        send_bits(8'h8F, 8);
        send_bits(8'h77, 8);
        frame_end;
        checks++; if (disp_ram !== 128'h0) begin errors++; $display("FAIL midrst_ignore_ram got=%h exp=0", disp_ram); end
        checks++; if ({disp_on, brightness} !== 4'h0) begin errors++; $display("FAIL midrst_ignore_ctl got=%h exp=0", {disp_on, brightness}); end
        checks++; if (upd_cnt !== u0) begin errors++; $display("FAIL midrst_ignore_upd got=%0d exp=0", upd_cnt - u0); end
        frame_begin;
        send_bits(8'hC0, 8); send_bits(8'h12, 8);
        frame_end;
        checks++; if (disp_ram !== 128'h12) begin errors++; $display("FAIL midrst_resume_ram got=%h exp=12", disp_ram); end
        checks++; if (upd_cnt !== u0 + 1) begin errors++; $display("FAIL midrst_resume_upd got=%0d exp=1", upd_cnt - u0); end
    endtask

    initial begin
        test_reset;
        test_auto_write;
        test_fixed_wrap;
        test_display;
        test_null_cmd;
        test_key_read;
        test_key_abort;
        test_partial;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
